// File: rtl/hamming_pkg.sv
// Shared Hamming (7,4) definitions: codeword layout, types and the
// parity/syndrome helpers used by both the encoder and the decoder paths.
package hamming_pkg;

  // Bit index in cw[6:0] of each codeword position (index = position - 1).
  localparam int unsigned IDX_P1 = 0;
  localparam int unsigned IDX_P2 = 1;
  localparam int unsigned IDX_D1 = 2;
  localparam int unsigned IDX_P4 = 3;
  localparam int unsigned IDX_D2 = 4;
  localparam int unsigned IDX_D3 = 5;
  localparam int unsigned IDX_D4 = 6;

  typedef logic [6:0] codeword_t;
  typedef logic [2:0] syndrome_t;
  typedef logic [3:0] nibble_t;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_HOLD    = 1'b1
  } rx_state_t;

  // Returns {p4, p2, p1} for data {d4, d3, d2, d1}.
  function automatic logic [2:0] calc_parity(input nibble_t d);
    calc_parity = {d[1] ^ d[2] ^ d[3],
                   d[0] ^ d[2] ^ d[3],
                   d[0] ^ d[1] ^ d[3]};
  endfunction

  function automatic codeword_t encode_nibble(input nibble_t d);
    logic [2:0] p;
    codeword_t  cw;
    p          = calc_parity(d);
    cw[IDX_P1] = p[0];
    cw[IDX_P2] = p[1];
    cw[IDX_D1] = d[0];
    cw[IDX_P4] = p[2];
    cw[IDX_D2] = d[1];
    cw[IDX_D3] = d[2];
    cw[IDX_D4] = d[3];
    return cw;
  endfunction

  // Returns {s4, s2, s1}; the value is the erroneous position, 0 when clean.
  function automatic syndrome_t calc_syndrome(input codeword_t cw);
    calc_syndrome = {cw[IDX_P4] ^ cw[IDX_D2] ^ cw[IDX_D3] ^ cw[IDX_D4],
                     cw[IDX_P2] ^ cw[IDX_D1] ^ cw[IDX_D3] ^ cw[IDX_D4],
                     cw[IDX_P1] ^ cw[IDX_D1] ^ cw[IDX_D2] ^ cw[IDX_D4]};
  endfunction

  function automatic nibble_t extract_data(input codeword_t cw);
    extract_data = {cw[IDX_D4], cw[IDX_D3], cw[IDX_D2], cw[IDX_D1]};
  endfunction

endpackage

// File: rtl/hamming74_correct.sv
// Combinational Hamming (7,4) single-error corrector: syndrome, flip of the
// indicated bit, and data extraction from the corrected word.
module hamming74_correct
  import hamming_pkg::*;
(
  input  codeword_t cw_i,
  output nibble_t   data_o,
  output syndrome_t syndrome_o,
  output logic      err_o
);

  syndrome_t syn_s;
  codeword_t fixed_s;

  // Syndrome k (1..7) names position k, i.e. bit k-1; zero leaves the word alone.
  always_comb begin
    syn_s   = calc_syndrome(cw_i);
    fixed_s = cw_i;
    for (int i = 0; i < 7; i++) begin
      fixed_s[i] = cw_i[i] ^ (syn_s == 3'(i + 1));
    end
  end

  assign data_o     = extract_data(fixed_s);
  assign syndrome_o = syn_s;
  assign err_o      = (syn_s != 3'd0);

endmodule

// File: rtl/hamming_serial_rx.sv
// Bit-serial Hamming (7,4) receiver: assembles codewords, corrects single-bit
// errors and presents nibbles through a one-entry valid/ready buffer.
module hamming_serial_rx
  import hamming_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             in_sof,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_data,
  output logic             out_err,
  output logic [2:0]       out_syndrome,
  output logic [CNT_W-1:0] err_count
);

  rx_state_t        state_q, state_d;
  logic [2:0]       bcnt_q, bcnt_d;
  logic [5:0]       sr_q, sr_d;
  nibble_t          data_q, data_d;
  logic             err_q, err_d;
  syndrome_t        syn_q, syn_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic      accept_s;
  logic      last_s;
  logic      hs_s;
  codeword_t cw_s;
  nibble_t   dec_data_s;
  syndrome_t dec_syn_s;
  logic      dec_err_s;

  assign out_valid = (state_q == ST_HOLD);
  // Stall only the 7th bit, and only when the buffer cannot drain this cycle.
  assign in_ready  = !((bcnt_q == 3'd6) && (state_q == ST_HOLD) && !out_ready);
  assign accept_s  = in_valid && in_ready;
  assign last_s    = accept_s && !in_sof && (bcnt_q == 3'd6);
  assign hs_s      = out_valid && out_ready;
  assign cw_s      = {in_bit, sr_q};

  hamming74_correct u_correct (
    .cw_i       (cw_s),
    .data_o     (dec_data_s),
    .syndrome_o (dec_syn_s),
    .err_o      (dec_err_s)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_COLLECT: begin
        if (last_s) state_d = ST_HOLD;
        else        state_d = ST_COLLECT;
      end
      ST_HOLD: begin
        if (hs_s && !last_s) state_d = ST_COLLECT;
        else                 state_d = ST_HOLD;
      end
      default: state_d = ST_COLLECT;
    endcase
  end

  always_comb begin
    bcnt_d = bcnt_q;
    sr_d   = sr_q;
    if (accept_s) begin
      if (in_sof) begin
        sr_d[0] = in_bit;
        bcnt_d  = 3'd1;
      end else if (bcnt_q == 3'd6) begin
        bcnt_d = 3'd0;
      end else begin
        for (int i = 0; i < 6; i++) begin
          if (bcnt_q == 3'(i)) sr_d[i] = in_bit;
          else                 sr_d[i] = sr_q[i];
        end
        bcnt_d = bcnt_q + 3'd1;
      end
    end else begin
      bcnt_d = bcnt_q;
    end
  end

  always_comb begin
    data_d = data_q;
    err_d  = err_q;
    syn_d  = syn_q;
    if (last_s) begin
      data_d = dec_data_s;
      err_d  = dec_err_s;
      syn_d  = dec_syn_s;
    end else begin
      data_d = data_q;
    end
  end

  // Count delivered corrected words, sticking at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (hs_s && err_q && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
    else                                           cnt_d = cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_COLLECT;
      bcnt_q  <= 3'd0;
      sr_q    <= 6'd0;
      data_q  <= 4'd0;
      err_q   <= 1'b0;
      syn_q   <= 3'd0;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      sr_q    <= sr_d;
      data_q  <= data_d;
      err_q   <= err_d;
      syn_q   <= syn_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_data     = data_q;
  assign out_err      = err_q;
  assign out_syndrome = syn_q;
  assign err_count    = cnt_q;

endmodule

// File: tb/tb_hamming_serial_rx.sv
// Directed scoreboard bench for hamming_serial_rx; a second instance with a
// 2-bit counter exercises counter saturation.
module tb_hamming_serial_rx;

  logic clk = 1'b0;
  logic rst, in_valid, in_bit, in_sof, out_ready;
  logic in_ready, out_valid, out_err;
  logic [3:0] out_data;
  logic [2:0] out_syndrome;
  logic [7:0] err_count;
  logic in_ready2, out_valid2, out_err2;
  logic [3:0] out_data2;
  logic [2:0] out_syndrome2;
  logic [1:0] err_count2;

  int checks = 0;
  int failures = 0;
  int exp_cnt8 = 0;
  int exp_cnt2 = 0;

  typedef struct packed {
    logic [3:0] data;
    logic       err;
    logic [2:0] syn;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  hamming_serial_rx dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .in_sof(in_sof),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err(out_err), .out_syndrome(out_syndrome),
    .err_count(err_count)
  );

  hamming_serial_rx #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .in_sof(in_sof),
    .in_ready(in_ready2), .out_valid(out_valid2), .out_ready(out_ready),
    .out_data(out_data2), .out_err(out_err2), .out_syndrome(out_syndrome2),
    .err_count(err_count2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference encoder: position k of the codeword lives in bit k-1.
  function automatic logic [6:0] make_cw(input logic [3:0] d, input int flip);
    logic [6:0] c;
    c[0] = d[0] ^ d[1] ^ d[3];
    c[1] = d[0] ^ d[2] ^ d[3];
    c[2] = d[0];
    c[3] = d[1] ^ d[2] ^ d[3];
    c[4] = d[1];
    c[5] = d[2];
    c[6] = d[3];
    if (flip > 0) c[flip-1] = ~c[flip-1];
    return c;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic sof);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_bit   = b;
    in_sof   = sof;
    @(negedge clk);
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic push_exp(input logic [3:0] d, input logic [2:0] syn);
    exp_t e;
    e.data = d;
    e.err  = (syn != 3'd0);
    e.syn  = syn;
    sb.push_back(e);
  endtask

  task automatic send_word(input logic [6:0] cw, input logic [3:0] d, input logic [2:0] syn,
                           input logic sof);
    push_exp(d, syn);
    for (int i = 0; i < 7; i++) send_bit(cw[i], (i == 0) ? sof : 1'b0);
  endtask

  // Output side of the scoreboard: every handshake pops one expected word.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      checks++;
      assert (sb.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_word observed=%0h expected=none", out_data);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("out_data", out_data, e.data);
        chk("out_err", out_err, e.err);
        chk("out_syndrome", out_syndrome, e.syn);
        chk("out_data_cnt2", out_data2, e.data);
        if (e.err) begin
          exp_cnt8 = (exp_cnt8 == 255) ? 255 : exp_cnt8 + 1;
          exp_cnt2 = (exp_cnt2 == 3) ? 3 : exp_cnt2 + 1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; in_sof = 1'b0; out_ready = 1'b1;
    idle(2);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_out_syndrome", out_syndrome, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    idle(1);

    // Clean word 7'h55 carrying 4'hB; out_valid must rise right after bit 7.
    push_exp(4'hB, 3'd0);
    for (int i = 0; i < 6; i++) send_bit(i[0] ? 1'b0 : 1'b1, (i == 0));
    chk("t1_valid_before", out_valid, 0);
    send_bit(1'b1, 1'b0);
    chk("t1_valid_after", out_valid, 1);
    chk("t1_data_reg", out_data, 4'hB);
    idle(2);
    chk("t1_valid_drop", out_valid, 0);

    // Position 5 flipped.
    send_word(7'h45, 4'hB, 3'd5, 1'b1);
    idle(3);
    chk("t2_err_count", err_count, 1);

    // Back-pressure: A held, B stalls on its 7th bit, both delivered in order.
    out_ready = 1'b0;
    send_word(make_cw(4'h3, 0), 4'h3, 3'd0, 1'b0);
    chk("t3_a_valid", out_valid, 1);
    push_exp(4'hC, 3'd2);
    for (int i = 0; i < 6; i++) send_bit(make_cw(4'hC, 2) >> i, 1'b0);
    chk("t3_a_stable", out_data, 4'h3);
    chk("t3_in_ready_low", in_ready, 0);
    in_valid = 1'b1; in_bit = make_cw(4'hC, 2) >> 6; in_sof = 1'b0;
    idle(3);
    chk("t3_a_still", out_data, 4'h3);
    chk("t3_stall_ready", in_ready, 0);
    out_ready = 1'b1;
    idle(1);
    in_valid = 1'b0;
    chk("t3_b_valid", out_valid, 1);
    chk("t3_b_data", out_data, 4'hC);
    idle(2);
    chk("t3_drained", out_valid, 0);
    chk("t3_sb_empty", sb.size(), 0);

    // Partial word abandoned by in_sof.
    for (int i = 0; i < 3; i++) send_bit(1'b1, (i == 0));
    send_word(7'h00, 4'h0, 3'd0, 1'b1);
    idle(3);
    chk("t4_sb_empty", sb.size(), 0);

    // All nibbles, error position cycling through none and 1..7.
    for (int d = 0; d < 16; d++) send_word(make_cw(4'(d), d % 8), 4'(d), 3'(d % 8), d[0]);
    idle(3);
    chk("t5_sb_empty", sb.size(), 0);
    chk("t5_err_count", err_count, exp_cnt8);
    chk("t5_err_count2", err_count2, exp_cnt2);

    // Asynchronous reset while HOLD and mid-word.
    out_ready = 1'b0;
    send_word(make_cw(4'h6, 0), 4'h6, 3'd0, 1'b1);
    for (int i = 0; i < 3; i++) send_bit(1'b1, (i == 0));
    #2 rst = 1'b1;
    #1;
    chk("ar_out_valid", out_valid, 0);
    chk("ar_out_data", out_data, 0);
    chk("ar_out_err", out_err, 0);
    chk("ar_out_syndrome", out_syndrome, 0);
    chk("ar_err_count", err_count, 0);
    chk("ar_in_ready", in_ready, 1);
    sb.delete();
    exp_cnt8 = 0;
    exp_cnt2 = 0;
    idle(1);
    rst = 1'b0;
    out_ready = 1'b1;
    send_word(make_cw(4'h9, 3), 4'h9, 3'd3, 1'b0);
    idle(3);
    chk("ar_sb_empty", sb.size(), 0);

    // Five more erroneous words saturate the 2-bit counter.
    for (int i = 0; i < 5; i++) send_word(make_cw(4'(i + 5), i + 1), 4'(i + 5), 3'(i + 1), 1'b1);
    idle(3);
    chk("sat_err_count8", err_count, 6);
    chk("sat_err_count2", err_count2, 3);
    chk("sat_model8", err_count, exp_cnt8);
    chk("final_sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hamming_serial_rx.md
# hamming_serial_rx

Serial front end for the Hamming (7,4) decoder path. Receives a bit-serial stream of 7-bit codewords, assembles each codeword, computes the syndrome, corrects any single-bit error, and presents the 4-bit data nibble on a valid/ready output with a one-entry buffer. Sits directly upstream of the nibble consumer and replaces the direct parallel encoder-to-decoder connection when codewords arrive over a 1-bit link. Keeps a saturating corrected-error counter.

## Interface
- CNT_W, 8, width of saturating error counter
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  in_bit is valid this cycle
- in_bit  in  1  serial codeword bit, position 1 first
- in_sof  in  1  with in_valid: this bit is position 1 (resynchronise)
- in_ready  out  1  bit accepted when in_valid && in_ready
- out_valid  out  1  out_data/out_syndrome hold a decoded codeword
- out_ready  in  1  consumer accepts when out_valid && out_ready
- out_data  out  4  corrected data {d4,d3,d2,d1}
- out_err  out  1  syndrome nonzero (single-bit error corrected)
- out_syndrome  out  3  {s4,s2,s1}; equals erroneous bit position, 0 = clean
- err_count  out  CNT_W  number of delivered words with out_err=1, saturates at all-ones

## Operation
- Codeword positions 1..7 = p1,p2,d1,p4,d2,d3,d4; stored as cw[6:0] with cw[0]=position 1.
- Parity: p1=d1^d2^d4, p2=d1^d3^d4, p4=d2^d3^d4. Syndrome s1=p1^d1^d2^d4, s2=p2^d1^d3^d4, s4=p4^d2^d3^d4.
- Correction: if syndrome=k (1..7) invert cw[k-1]; extract data from corrected word. Syndrome 0: no change.
- Bit counter bcnt 0..6, shift register sr[5:0]. Accepted bit with in_sof=1: stored as position 1, bcnt<=1 (discarding any partial word). Otherwise stored at position bcnt+1, bcnt increments.
- On acceptance of the 7th bit (bcnt=6, in_sof=0): full codeword decoded combinationally, result loaded into output buffer, bcnt<=0.
- FSM: COLLECT (buffer empty) / HOLD (buffer full). COLLECT→HOLD on 7th bit. HOLD→COLLECT on output handshake with no simultaneous 7th bit; handshake + 7th bit same cycle stays HOLD with new word loaded.
- in_ready = 0 only when bcnt=6 and buffer full and out_ready=0; otherwise 1. No codeword is ever dropped.
- in_sof on an accepted bit while bcnt=6 and buffer full is permitted (it is position 1, not 7th bit).
- err_count increments on each output handshake with out_err=1; holds at 2^CNT_W-1.

## Timing
- Reset: out_valid=0, out_data=0, out_err=0, out_syndrome=0, err_count=0, bcnt=0, FSM=COLLECT; in_ready=1.
- Latency: out_valid rises the cycle after the 7th bit is accepted; outputs registered.
- Outputs stable while out_valid && !out_ready.
- Throughput: one codeword per 7 accepted bits; full rate sustained with out_ready=1.
- Reset mid-word or mid-HOLD: partial word and buffered word discarded immediately.

## Structure
- Package hamming_pkg: position constants, codeword_t (7-bit), syndrome_t (3-bit), parity/syndrome functions shared with encoder.
- Sub-module hamming74_correct: combinational cw[6:0] → data[3:0], syndrome[2:0], err. Rest (shift, counter, FSM, buffer, counter) in top.

## Test plan
- Data 4'b1011 → cw 7'h55, send bits 1,0,1,0,1,0,1, out_ready=1 → out_data=4'hB, out_syndrome=0, out_err=0, out_valid one cycle after 7th bit.
- Same word with position 5 flipped (cw 7'h45) → out_data=4'hB, out_syndrome=3'd5, out_err=1, err_count=1 after handshake.
- out_ready=0, two codewords back-to-back → first held stable, in_ready=0 at 7th bit of second; release out_ready → both delivered in order, none lost.
- 3 bits then in_sof with new word 7'h00 → partial discarded, out_data=0, syndrome=0.
- Assert rst during HOLD and mid-word → all outputs to reset values asynchronously; next full word decodes correctly.
- CNT_W=2, five erroneous words delivered → err_count saturates at 3.
